// File: rtl/clk_gate_ctrl.sv
// Enable controller for the clk_d clock-gating cell: wake settle delay before grant, idle hysteresis before gating.
// Optional CLK_GATE_STATS_EN adds stats_clr / on_cycles (saturating count of gated-clock-running edges).
module clk_gate_ctrl #(
  parameter int N           = 2,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
`ifdef CLK_GATE_STATS_EN
  input  logic         stats_clr,
  output logic [31:0]  on_cycles,
`endif
  output logic [N-1:0] ack,
  output logic         gate_en,
  output logic [1:0]   state
);

  localparam int CNT_MAX = (WAKE_CYCLES > IDLE_CYCLES) ? WAKE_CYCLES : IDLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_WAKE = 2'd1,
    S_ON   = 2'd2,
    S_IDLE = 2'd3
  } state_t;

  state_t        st;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st      <= S_OFF;
      gate_en <= 1'b0;
      ack     <= '0;
      cnt     <= '0;
    end else begin
      case (st)
        S_OFF: begin
          if (|req) begin
            st      <= S_WAKE;
            gate_en <= 1'b1;
            cnt     <= CW'(WAKE_CYCLES - 1);
          end
        end
        // WAKE runs to completion regardless of req so the gated clock is settled before any grant.
        S_WAKE: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            st  <= S_ON;
            ack <= req;
          end
        end
        S_ON: begin
          if (req == '0) begin
            st  <= S_IDLE;
            ack <= '0;
            cnt <= CW'(IDLE_CYCLES - 1);
          end else begin
            ack <= req;
          end
        end
        S_IDLE: begin
          // A request arriving on the expiry edge still wins: no gate_en chatter.
          if (|req) begin
            st  <= S_ON;
            ack <= req;
            cnt <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            st      <= S_OFF;
            gate_en <= 1'b0;
          end
        end
      endcase
    end
  end

  assign state = st;

`ifdef CLK_GATE_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || stats_clr) begin
      on_cycles <= '0;
    end else if (gate_en) begin
      on_cycles <= sat_inc32(on_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl: timestamp-based reference model pushes expectations, a monitor compares.
// Also exercises the CLK_GATE_STATS_EN build when that macro is defined.
module tb_clk_gate_ctrl;

  localparam int N    = 2;
  localparam int WAKE = 2;
  localparam int IDLE = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] ack;
  logic         gate_en;
  logic [1:0]   state;
`ifdef CLK_GATE_STATS_EN
  logic         stats_clr;
  logic [31:0]  on_cycles;
`endif

  clk_gate_ctrl #(.N(N), .WAKE_CYCLES(WAKE), .IDLE_CYCLES(IDLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
`ifdef CLK_GATE_STATS_EN
    .stats_clr (stats_clr),
    .on_cycles (on_cycles),
`endif
    .ack       (ack),
    .gate_en   (gate_en),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   st;
    logic         g;
    logic [N-1:0] a;
    logic [31:0]  oc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: gate status, edge index when gate rose, start of current zero-request run.
  bit          m_gate       = 0;
  int          m_t_on       = 0;
  int          m_zero_start = -1;
  int          m_edge       = 0;
  logic [31:0] m_on         = '0;

  task automatic model(input logic rn, input logic [N-1:0] r, input logic clr);
    exp_t x;
    int   first_zero;
    bit   g_prev;
    g_prev = m_gate;
    x.a    = '0;
    x.st   = 2'd0;
    if (r != '0) m_zero_start = -1;
    else if (m_zero_start < 0) m_zero_start = m_edge;
    if (!rn) begin
      m_gate = 0;
      x.st   = 2'd0;
    end else if (!m_gate) begin
      if (r != '0) begin
        m_gate = 1;
        m_t_on = m_edge;
        x.st   = 2'd1;
      end
    end else if (m_edge < m_t_on + WAKE) begin
      x.st = 2'd1;
    end else if (m_edge == m_t_on + WAKE) begin
      x.st = 2'd2;
      x.a  = r;
    end else begin
      // Gate drops once IDLE+1 consecutive zero-request edges have elapsed after the first ON edge.
      first_zero = (m_zero_start > m_t_on + WAKE + 1) ? m_zero_start : m_t_on + WAKE + 1;
      if (r == '0 && (m_edge - first_zero) >= IDLE) begin
        m_gate = 0;
        x.st   = 2'd0;
      end else begin
        x.a  = r;
        x.st = (r != '0) ? 2'd2 : 2'd3;
      end
    end
    x.g = m_gate;
    if (!rn || clr) m_on = '0;
    else if (g_prev && m_on != 32'hFFFF_FFFF) m_on = m_on + 32'd1;
    x.oc = m_on;
    exp_q.push_back(x);
    m_edge++;
  endtask

  task automatic step(input logic rn, input logic [N-1:0] r, input logic clr);
    @(negedge clk);
    rst_n = rn;
    req   = r;
`ifdef CLK_GATE_STATS_EN
    stats_clr = clr;
`endif
    model(rn, r, clr);
  endtask

  task automatic hold(input logic rn, input logic [N-1:0] r, input int n);
    for (int i = 0; i < n; i++) step(rn, r, 1'b0);
  endtask

  // Monitor: every active edge produces a registered output word to compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (state !== e.st) begin
          failures++;
          $display("FAIL state @%0t: got %0d expected %0d", $time, state, e.st);
        end
        checks++;
        if (gate_en !== e.g) begin
          failures++;
          $display("FAIL gate_en @%0t: got %0b expected %0b", $time, gate_en, e.g);
        end
        checks++;
        if (ack !== e.a) begin
          failures++;
          $display("FAIL ack @%0t: got %b expected %b", $time, ack, e.a);
        end
`ifdef CLK_GATE_STATS_EN
        checks++;
        if (on_cycles !== e.oc) begin
          failures++;
          $display("FAIL on_cycles @%0t: got %0d expected %0d", $time, on_cycles, e.oc);
        end
`endif
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    logic         rn;
    int           len;
    rst_n = 1'b0;
    req   = '0;
`ifdef CLK_GATE_STATS_EN
    stats_clr = 1'b0;
`endif
    // Reset held with demand present, then release: wake, grant, then idle timeout.
    hold(1'b0, 2'b11, 3);
    hold(1'b1, 2'b11, 6);
    hold(1'b1, 2'b01, 3);
    hold(1'b1, 2'b00, 8);
    // Hysteresis re-grant from IDLE.
    hold(1'b1, 2'b01, 5);
    hold(1'b1, 2'b00, 2);
    hold(1'b1, 2'b10, 3);
    hold(1'b1, 2'b00, 8);
    // Short pulse from OFF (also measured by on_cycles in the stats build).
    step(1'b1, 2'b00, 1'b1);
    hold(1'b1, 2'b01, 1);
    hold(1'b1, 2'b00, 10);
    // Request arriving exactly on IDLE expiry.
    hold(1'b1, 2'b11, 4);
    hold(1'b1, 2'b00, 4);
    hold(1'b1, 2'b01, 3);
    hold(1'b1, 2'b00, 8);
    // Reset mid-WAKE.
    hold(1'b1, 2'b11, 2);
    hold(1'b0, 2'b11, 1);
    hold(1'b1, 2'b00, 3);
    // Statistics clear while gate is running.
    hold(1'b1, 2'b10, 5);
    step(1'b1, 2'b10, 1'b1);
    hold(1'b1, 2'b10, 3);
    hold(1'b1, 2'b00, 8);
    // Randomized bursts with occasional resets and clears.
    for (int b = 0; b < 120; b++) begin
      r   = ($urandom_range(0, 2) == 0) ? 2'b00 : N'($urandom_range(0, 3));
      len = $urandom_range(1, 9);
      rn  = ($urandom_range(0, 30) != 0);
      for (int i = 0; i < len; i++) begin
        step(rn, r, ($urandom_range(0, 20) == 0));
        rn = 1'b1;
      end
    end
    hold(1'b1, 2'b00, 10);
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
